// File: rtl/sync_fifo_bypass_arb.sv
// sync_fifo_bypass_arb
//   NCH write channels, each with its own DEPTH-entry FIFO, merged onto a single
//   registered valid/ready output by a round-robin arbiter. A write to an empty
//   channel that wins arbitration goes straight to the output register (bypass).
//   Optional feature macro: SFB_OVF_EN adds the sticky per-channel o_Overflow
//   flag for writes dropped at a full channel.
module sync_fifo_bypass_arb #(
    parameter  int NCH   = 3,
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 64,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   CLK,
    input  logic                   Reset_n,
    input  logic [NCH-1:0]         i_WrEn,
    input  logic [NCH*WIDTH-1:0]   i_WrData,
    output logic [NCH-1:0]         o_Full,
    output logic [NCH-1:0]         o_Empty,
    output logic                   o_Valid,
    output logic [WIDTH-1:0]       o_Data,
    output logic [CHW-1:0]         o_Chan,
    input  logic                   i_Ready
`ifdef SFB_OVF_EN
    ,
    output logic [NCH-1:0]         o_Overflow
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem    [NCH][DEPTH];
    logic [PW-1:0]    wr_ptr [NCH];
    logic [PW-1:0]    rd_ptr [NCH];
    logic [CW-1:0]    count  [NCH];

    logic [CHW-1:0]   last_grant;
    logic [CHW-1:0]   grant_idx;
    logic             grant_found;
    logic             grant_vld;
    logic             load;
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   pop;
    logic [NCH-1:0]   bypass;
    logic [NCH-1:0]   accept;
    logic [WIDTH-1:0] grant_data;

    // Status flags come straight from the occupancy counters
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            o_Full[c]  = (count[c] == CW'(DEPTH));
            o_Empty[c] = (count[c] == '0);
        end
    end

    // Round-robin arbiter: first requester after the last granted channel
    always_comb begin
        int idx;
        idx         = 0;
        load        = !o_Valid || i_Ready;
        req         = ~o_Empty | i_WrEn;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(last_grant) + k) % NCH;
            if (!grant_found && req[idx]) begin
                grant_found = 1'b1;
                grant_idx   = CHW'(idx);
            end
        end
        grant_vld = load && grant_found;
    end

    // Per-channel pop/bypass/push decisions; a full channel may still take a
    // write when it pops in the same cycle
    always_comb begin
        pop    = '0;
        bypass = '0;
        accept = '0;
        for (int c = 0; c < NCH; c++) begin
            pop[c]    = grant_vld && (grant_idx == CHW'(c)) && !o_Empty[c];
            bypass[c] = grant_vld && (grant_idx == CHW'(c)) && o_Empty[c];
            accept[c] = i_WrEn[c] && !bypass[c] &&
                        ((count[c] != CW'(DEPTH)) || pop[c]);
        end
    end

    // Word presented to the output register for the granted channel
    always_comb begin
        if (o_Empty[grant_idx])
            grant_data = i_WrData[int'(grant_idx)*WIDTH +: WIDTH];
        else
            grant_data = mem[grant_idx][rd_ptr[grant_idx]];
    end

    // Output register and arbiter history; holds while stalled
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            o_Valid    <= 1'b0;
            o_Data     <= '0;
            o_Chan     <= '0;
            last_grant <= CHW'(NCH - 1);
        end else if (load) begin
            if (grant_vld) begin
                o_Valid    <= 1'b1;
                o_Data     <= grant_data;
                o_Chan     <= grant_idx;
                last_grant <= grant_idx;
            end else begin
                o_Valid <= 1'b0;
            end
        end
    end

    // Pointers and occupancy counts; push and pop together leave count unchanged
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (accept[c])
                    wr_ptr[c] <= wr_ptr[c] + PW'(1);
                if (pop[c])
                    rd_ptr[c] <= rd_ptr[c] + PW'(1);
                case ({accept[c], pop[c]})
                    2'b10:   count[c] <= count[c] + CW'(1);
                    2'b01:   count[c] <= count[c] - CW'(1);
                    default: count[c] <= count[c];
                endcase
            end
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge CLK) begin
        for (int c = 0; c < NCH; c++) begin
            if (accept[c])
                mem[c][wr_ptr[c]] <= i_WrData[c*WIDTH +: WIDTH];
        end
    end

`ifdef SFB_OVF_EN
    // Sticky record of writes dropped at a full channel
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)
            o_Overflow <= '0;
        else
            o_Overflow <= o_Overflow | (i_WrEn & ~bypass & ~accept);
    end
`endif

endmodule

// File: tb/tb_sync_fifo_bypass_arb.sv
// Testbench for sync_fifo_bypass_arb: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model.
module tb_sync_fifo_bypass_arb;

    localparam int NCH   = 3;
    localparam int DEPTH = 8;
    localparam int WIDTH = 64;
    localparam int CHW   = 2;

    logic                 CLK = 1'b0;
    logic                 Reset_n = 1'b1;
    logic [NCH-1:0]       i_WrEn = '0;
    logic [NCH*WIDTH-1:0] i_WrData = '0;
    logic [NCH-1:0]       o_Full;
    logic [NCH-1:0]       o_Empty;
    logic                 o_Valid;
    logic [WIDTH-1:0]     o_Data;
    logic [CHW-1:0]       o_Chan;
    logic                 i_Ready = 1'b0;
`ifdef SFB_OVF_EN
    logic [NCH-1:0]       o_Overflow;
`endif

    always #5 CLK = ~CLK;

    sync_fifo_bypass_arb #(.NCH(NCH), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .CLK        (CLK),
        .Reset_n    (Reset_n),
        .i_WrEn     (i_WrEn),
        .i_WrData   (i_WrData),
        .o_Full     (o_Full),
        .o_Empty    (o_Empty),
        .o_Valid    (o_Valid),
        .o_Data     (o_Data),
        .o_Chan     (o_Chan),
        .i_Ready    (i_Ready)
`ifdef SFB_OVF_EN
        ,
        .o_Overflow (o_Overflow)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: one queue per channel plus the output register contents
    logic [WIDTH-1:0] mq [NCH][$];
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_chan;
    int               m_last;
    logic [NCH-1:0]   m_ovf;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) mq[c].delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_chan  = 0;
        m_last  = NCH - 1;
        m_ovf   = '0;
    endtask

    task automatic model_step(input logic [NCH-1:0] wr, input logic [NCH*WIDTH-1:0] wd,
                              input logic rdy);
        logic [NCH-1:0] byp;
        int g;
        byp = '0;
        g   = -1;
        if (!m_valid || rdy) begin
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (m_last + k) % NCH;
                if (g < 0 && (mq[c].size() > 0 || wr[c])) g = c;
            end
            if (g >= 0) begin
                m_valid = 1'b1;
                m_chan  = g;
                m_last  = g;
                if (mq[g].size() == 0) begin
                    m_data = wd[g*WIDTH +: WIDTH];
                    byp[g] = 1'b1;
                end else begin
                    m_data = mq[g].pop_front();
                end
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (wr[c] && !byp[c]) begin
                if (mq[c].size() < DEPTH) mq[c].push_back(wd[c*WIDTH +: WIDTH]);
                else m_ovf[c] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        logic [NCH-1:0] ef, ee;
        for (int c = 0; c < NCH; c++) begin
            ef[c] = (mq[c].size() == DEPTH);
            ee[c] = (mq[c].size() == 0);
        end
        chk("valid", 64'(o_Valid), 64'(m_valid));
        chk("data",  o_Data, m_data);
        chk("chan",  64'(o_Chan), 64'(m_chan));
        chk("full",  64'(o_Full), 64'(ef));
        chk("empty", 64'(o_Empty), 64'(ee));
`ifdef SFB_OVF_EN
        chk("ovf",   64'(o_Overflow), 64'(m_ovf));
`endif
    endtask

    // Apply inputs at a falling edge, clock once, check at the next falling edge
    task automatic step(input logic [NCH-1:0] wr, input logic [NCH*WIDTH-1:0] wd, input logic rdy);
        i_WrEn   = wr;
        i_WrData = wd;
        i_Ready  = rdy;
        model_step(wr, wd, rdy);
        @(posedge CLK);
        @(negedge CLK);
        compare_all();
    endtask

    task automatic hard_reset();
        i_WrEn  = '0;
        i_Ready = 1'b0;
        Reset_n = 1'b0;
        #1;
        chk("rst_valid", 64'(o_Valid), 64'd0);
        chk("rst_empty", 64'(o_Empty), 64'h7);
        chk("rst_full",  64'(o_Full), 64'd0);
        chk("rst_data",  o_Data, 64'd0);
        chk("rst_chan",  64'(o_Chan), 64'd0);
        model_reset();
        @(negedge CLK);
        Reset_n = 1'b1;
    endtask

    function automatic logic [NCH*WIDTH-1:0] pack3(input logic [63:0] a, input logic [63:0] b,
                                                   input logic [63:0] c);
        return {c, b, a};
    endfunction

    function automatic logic [NCH*WIDTH-1:0] rnd_data();
        logic [NCH*WIDTH-1:0] d;
        for (int c = 0; c < NCH; c++) d[c*WIDTH +: WIDTH] = {$urandom, $urandom};
        return d;
    endfunction

    logic [63:0] exp_d [6];
    int          exp_c [6];

    initial begin
        model_reset();
        @(negedge CLK);
        hard_reset();
        compare_all();

        // bypass latency
        step(3'b010, pack3(64'h0, 64'hA5, 64'h0), 1'b1);
        chk("t1_valid", 64'(o_Valid), 64'd1);
        chk("t1_data",  o_Data, 64'hA5);
        chk("t1_chan",  64'(o_Chan), 64'd1);
        chk("t1_empty", 64'(o_Empty), 64'h7);

        // round robin
        hard_reset();
        step(3'b111, pack3(64'h00, 64'h10, 64'h20), 1'b0);
        step(3'b111, pack3(64'h01, 64'h11, 64'h21), 1'b0);
        exp_d = '{64'h00, 64'h10, 64'h20, 64'h01, 64'h11, 64'h21};
        exp_c = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < 6; i++) begin
            chk("t2_chan", 64'(o_Chan), 64'(exp_c[i]));
            chk("t2_data", o_Data, exp_d[i]);
            step(3'b000, '0, 1'b1);
        end
        chk("t2_drained", 64'(o_Valid), 64'd0);

        // order with bypass request on a non-empty channel
        hard_reset();
        step(3'b001, pack3(64'hA, 0, 0), 1'b0);
        step(3'b001, pack3(64'hB, 0, 0), 1'b0);
        step(3'b001, pack3(64'hC, 0, 0), 1'b1);
        chk("t3_head", o_Data, 64'hB);
        chk("t3_kept", 64'(o_Empty[0]), 64'd0);
        step(3'b000, '0, 1'b1);
        chk("t3_new", o_Data, 64'hC);

        // full channel, dropped write, push while popping a full channel
        hard_reset();
        for (int i = 0; i < 9; i++) step(3'b100, pack3(0, 0, 64'h200 + 64'(i)), 1'b0);
        chk("t4_full", 64'(o_Full[2]), 64'd1);
        chk("t4_first", o_Data, 64'h200);
        step(3'b100, pack3(0, 0, 64'h2FF), 1'b0);
`ifdef SFB_OVF_EN
        chk("t4_ovf", 64'(o_Overflow[2]), 64'd1);
`endif
        step(3'b100, pack3(0, 0, 64'h2AA), 1'b1);
        chk("t4_pop_push_full", 64'(o_Full[2]), 64'd1);
        chk("t4_second", o_Data, 64'h201);
        for (int i = 0; i < 9; i++) step(3'b000, '0, 1'b1);

        // stall hold
        hard_reset();
        step(3'b001, pack3(64'hD, 0, 0), 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(3'b110, rnd_data(), 1'b0);
            chk("t5_hold_data", o_Data, 64'hD);
            chk("t5_hold_chan", 64'(o_Chan), 64'd0);
        end
        for (int i = 0; i < 12; i++) step(3'b000, '0, 1'b1);

        // randomized traffic: heavy fill phase then balanced phase
        for (int i = 0; i < 400; i++) begin
            logic rdy;
            rdy = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(3'($urandom_range(0, 7)), rnd_data(), rdy);
        end

        // reset in the middle of traffic
        for (int i = 0; i < 6; i++) step(3'b111, rnd_data(), 1'b0);
        hard_reset();
        step(3'b111, rnd_data(), 1'b1);
        chk("t6_prio", 64'(o_Chan), 64'd0);
        for (int i = 0; i < 40; i++) step(3'b000, '0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
